// File: rtl/prbs_pkg.sv
// ============================================================================
//  prbs_pkg
//  Shared definitions for the PRBS generator/checker: polynomial encodings,
//  tap positions, checker state encoding and a popcount helper.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package prbs_pkg;

  // poly_sel encodings
  localparam logic [1:0] POLY_PRBS7  = 2'd0;
  localparam logic [1:0] POLY_PRBS15 = 2'd1;
  localparam logic [1:0] POLY_PRBS23 = 2'd2;
  localparam logic [1:0] POLY_PRBS31 = 2'd3;

  // LFSR length N and second tap T for x^N + x^T + 1
  localparam int PRBS7_N  = 7;
  localparam int PRBS7_T  = 6;
  localparam int PRBS15_N = 15;
  localparam int PRBS15_T = 14;
  localparam int PRBS23_N = 23;
  localparam int PRBS23_T = 18;
  localparam int PRBS31_N = 31;
  localparam int PRBS31_T = 28;

  // State register is sized for the longest polynomial
  localparam int STATE_W = 31;

  // Widest supported beat and the popcount result width that covers it
  localparam int MAX_DATA_W = 256;
  localparam int POP_W      = 9;

  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  // Keeps only the N significant state bits of the selected polynomial
  function automatic logic [STATE_W-1:0] state_mask(input logic [1:0] sel);
    logic [STATE_W-1:0] m;
    case (sel)
      POLY_PRBS7:  m = STATE_W'({PRBS7_N{1'b1}});
      POLY_PRBS15: m = STATE_W'({PRBS15_N{1'b1}});
      POLY_PRBS23: m = STATE_W'({PRBS23_N{1'b1}});
      default:     m = {STATE_W{1'b1}};
    endcase
    return m;
  endfunction

  // Number of set bits in a (zero-extended) beat
  function automatic logic [POP_W-1:0] popcount(input logic [MAX_DATA_W-1:0] v);
    logic [POP_W-1:0] c;
    c = '0;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      c = c + POP_W'(v[i]);
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prbs_step.sv
// ============================================================================
//  prbs_step
//  Combinational advance of a Fibonacci LFSR by DATA_W steps. The first
//  generated bit lands in beat[DATA_W-1], the last in beat[0].
//  Revision: 1.0
// ============================================================================
`default_nettype none

module prbs_step
  import prbs_pkg::*;
#(
  parameter int DATA_W = 128
) (
  input  logic [1:0]         poly_sel,
  input  logic [STATE_W-1:0] state,
  output logic [STATE_W-1:0] next_state,
  output logic [DATA_W-1:0]  beat
);

  logic [STATE_W-1:0] s;
  logic               nb;

  // Unrolled LFSR: each step shifts the feedback bit in at the bottom
  always_comb begin
    s    = state;
    nb   = 1'b0;
    beat = '0;
    for (int i = 0; i < DATA_W; i++) begin
      case (poly_sel)
        POLY_PRBS7:  nb = s[PRBS7_N-1]  ^ s[PRBS7_T-1];
        POLY_PRBS15: nb = s[PRBS15_N-1] ^ s[PRBS15_T-1];
        POLY_PRBS23: nb = s[PRBS23_N-1] ^ s[PRBS23_T-1];
        default:     nb = s[PRBS31_N-1] ^ s[PRBS31_T-1];
      endcase
      s = {s[STATE_W-2:0], nb};
      beat[DATA_W-1-i] = nb;
    end
    // Bits above N are shifted-in history only; drop them
    next_state = s & state_mask(poly_sel);
  end

endmodule

`default_nettype wire

// File: rtl/prbs_gen_chk.sv
// ============================================================================
//  prbs_gen_chk
//  PRBS generator plus self-synchronising checker with lock FSM and
//  saturating beat/bit error counters.
//  Optional feature macro: PRBS_ERR_INJECT_EN (single-bit error injection
//  on dout[0] of the next generated beat after an inject_err rising edge).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module prbs_gen_chk
  import prbs_pkg::*;
#(
  parameter int          DATA_W     = 128,
  parameter logic [30:0] PRBS_INIT  = 31'h7FFF_FFFF,
  parameter int          LOCK_CNT   = 8,
  parameter int          UNLOCK_ERR = 4,
  parameter int          ERR_CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           poly_sel,
  input  logic                 gen_en,
  output logic [DATA_W-1:0]    dout,
  output logic                 dout_vld,
  input  logic                 inject_err,
  input  logic                 chk_vld,
  input  logic [DATA_W-1:0]    chk_din,
  input  logic                 clr_cnt,
  output logic                 locked,
  output logic                 err_beat,
  output logic [ERR_CNT_W-1:0] err_beat_cnt,
  output logic [ERR_CNT_W-1:0] err_bit_cnt
);

  localparam int CLEAN_W = $clog2(LOCK_CNT + 1);
  localparam int RUN_W   = $clog2(UNLOCK_ERR + 1);
  // Sum width also covers a full-beat popcount when ERR_CNT_W is small
  localparam int SUM_W   = ((ERR_CNT_W > POP_W) ? ERR_CNT_W : POP_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({ERR_CNT_W{1'b1}});

  logic [1:0]         poly_q;
  logic               poly_chg;
  logic [STATE_W-1:0] gen_state;
  logic [STATE_W-1:0] gen_next;
  logic [DATA_W-1:0]  gen_beat;
  logic               inj_flip;

  chk_state_t         chk_state;
  logic [STATE_W-1:0] pred_state;
  logic [STATE_W-1:0] pred_next;
  logic [DATA_W-1:0]  pred_beat;
  logic [CLEAN_W-1:0] clean_cnt;
  logic [RUN_W-1:0]   err_run;
  logic               mismatch;
  logic               count_err;
  logic [POP_W-1:0]   err_pop;
  logic [SUM_W-1:0]   beat_sum;
  logic [SUM_W-1:0]   bit_sum;

  assign poly_chg = (poly_sel != poly_q);

  prbs_step #(.DATA_W(DATA_W)) u_gen_step (
    .poly_sel   (poly_sel),
    .state      (gen_state),
    .next_state (gen_next),
    .beat       (gen_beat)
  );

  prbs_step #(.DATA_W(DATA_W)) u_chk_step (
    .poly_sel   (poly_sel),
    .state      (pred_state),
    .next_state (pred_next),
    .beat       (pred_beat)
  );

`ifdef PRBS_ERR_INJECT_EN
  logic [2:0] inj_sync;
  logic       inj_armed;

  // Resample the request and arm a one-shot flip on its rising edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inj_sync  <= '0;
      inj_armed <= 1'b0;
    end else begin
      inj_sync <= {inj_sync[1:0], inject_err};
      if (inj_sync[1] && !inj_sync[2]) begin
        inj_armed <= 1'b1;
      end else if (gen_en && !poly_chg) begin
        inj_armed <= 1'b0;
      end
    end
  end

  assign inj_flip = inj_armed;
`else
  logic unused_inject_err;
  assign unused_inject_err = inject_err;
  assign inj_flip          = 1'b0;
`endif

  // Generator: a poly_sel change restarts the sequence from the seed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      poly_q    <= POLY_PRBS7;
      gen_state <= PRBS_INIT;
      dout      <= '0;
      dout_vld  <= 1'b0;
    end else begin
      poly_q <= poly_sel;
      if (poly_chg) begin
        gen_state <= PRBS_INIT;
        dout_vld  <= 1'b0;
      end else if (gen_en) begin
        gen_state <= gen_next;
        dout      <= gen_beat ^ DATA_W'(inj_flip);
        dout_vld  <= 1'b1;
      end else begin
        dout_vld  <= 1'b0;
      end
    end
  end

  assign mismatch  = (chk_din != pred_beat);
  assign count_err = (chk_state == LOCKED) && chk_vld && mismatch && !poly_chg;

  // Checker lock FSM; in LOCKED the prediction free-runs so each error counts once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_state  <= SEEK;
      pred_state <= '0;
      clean_cnt  <= '0;
      err_run    <= '0;
      locked     <= 1'b0;
      err_beat   <= 1'b0;
    end else begin
      err_beat <= 1'b0;
      if (poly_chg) begin
        chk_state <= SEEK;
        locked    <= 1'b0;
      end else if (chk_vld) begin
        case (chk_state)
          SEEK: begin
            // The newest N received bits are exactly the LFSR state
            pred_state <= chk_din[STATE_W-1:0] & state_mask(poly_sel);
            clean_cnt  <= '0;
            chk_state  <= VERIFY;
          end
          VERIFY: begin
            pred_state <= pred_next;
            if (mismatch) begin
              err_beat  <= 1'b1;
              chk_state <= SEEK;
            end else if (clean_cnt == CLEAN_W'(LOCK_CNT - 1)) begin
              err_run   <= '0;
              locked    <= 1'b1;
              chk_state <= LOCKED;
            end else begin
              clean_cnt <= clean_cnt + CLEAN_W'(1);
            end
          end
          LOCKED: begin
            pred_state <= pred_next;
            if (mismatch) begin
              err_beat <= 1'b1;
              if (err_run == RUN_W'(UNLOCK_ERR - 1)) begin
                locked    <= 1'b0;
                chk_state <= SEEK;
              end else begin
                err_run <= err_run + RUN_W'(1);
              end
            end else begin
              err_run <= '0;
            end
          end
          default: begin
            locked    <= 1'b0;
            chk_state <= SEEK;
          end
        endcase
      end
    end
  end

  assign err_pop  = popcount(MAX_DATA_W'(chk_din ^ pred_beat));
  assign beat_sum = SUM_W'(err_beat_cnt) + SUM_W'(1);
  assign bit_sum  = SUM_W'(err_bit_cnt) + SUM_W'(err_pop);

  // Saturating error counters; clear has priority over a same-cycle error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_beat_cnt <= '0;
      err_bit_cnt  <= '0;
    end else if (clr_cnt) begin
      err_beat_cnt <= '0;
      err_bit_cnt  <= '0;
    end else if (count_err) begin
      err_beat_cnt <= (beat_sum > CNT_MAX) ? {ERR_CNT_W{1'b1}} : beat_sum[ERR_CNT_W-1:0];
      err_bit_cnt  <= (bit_sum  > CNT_MAX) ? {ERR_CNT_W{1'b1}} : bit_sum[ERR_CNT_W-1:0];
    end
  end

endmodule

`default_nettype wire

// File: doc/prbs_gen_chk.md
# prbs_gen_chk

Parametrised PRBS generator and self-synchronising checker for the DDR3 example-design traffic path. It replaces the fixed 128-bit PRBS31 block with three additions: selectable width, a selectable polynomial, and a lock state machine with saturating error counters. The generator feeds write data to the memory controller. The checker compares read-back data and reports lock, per-beat errors and cumulative beat and bit error counts.

## Interface
- DATA_W, 128: beat width. Must be a multiple of 8 in the range 32..256.
- PRBS_INIT, 31'h7FFF_FFFF: generator seed. The low N bits are used for PRBS-N. A zero seed is illegal.
- LOCK_CNT, 8: number of consecutive clean beats needed to declare lock.
- UNLOCK_ERR, 4: number of consecutive errored beats, while locked, that force a return to SEEK.
- ERR_CNT_W, 32: width of the error counters.
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- poly_sel  in  2  polynomial select: 0 = PRBS7 (x^7+x^6+1), 1 = PRBS15 (x^15+x^14+1), 2 = PRBS23 (x^23+x^18+1), 3 = PRBS31 (x^31+x^28+1)
- gen_en  in  1  advance the generator by one beat
- dout  out  DATA_W  generated beat
- dout_vld  out  1  dout holds a new beat
- inject_err  in  1  error-injection request (active only when compiled in)
- chk_vld  in  1  chk_din is valid this cycle
- chk_din  in  DATA_W  received beat
- clr_cnt  in  1  synchronous clear of both counters
- locked  out  1  checker is in the LOCKED state
- err_beat  out  1  one-cycle pulse when a checked beat contained at least one error
- err_beat_cnt  out  ERR_CNT_W  number of errored beats while locked, saturating
- err_bit_cnt  out  ERR_CNT_W  number of errored bits while locked, saturating

## Operation
- LFSR: Fibonacci form with state s[N-1:0]. Each step: new = s[N-1]^s[T-1]; s becomes {s[N-2:0], new}; the output bit is new.
- Bit order: dout[DATA_W-1] is the first generated bit and dout[0] the last. One beat equals DATA_W steps, computed combinationally.
- Generator: on reset, the state is PRBS_INIT[N-1:0]. On each gen_en cycle, the state advances one beat and dout is updated.
- Checker states:
  - SEEK: on chk_vld, load the state from chk_din[N-1:0] (the last N received bits). Go to VERIFY with clean count 0.
  - VERIFY: on chk_vld, compare chk_din with the predicted beat, then advance the predicted state. On a mismatch, return to SEEK. On a match, increment the clean count; when it reaches LOCK_CNT, go to LOCKED.
  - LOCKED: the predicted state free-runs and is never reloaded from the input, so a single bit error is counted exactly once.
    - On a mismatch: pulse err_beat, add 1 to err_beat_cnt, and add popcount(chk_din ^ expected) to err_bit_cnt.
    - After UNLOCK_ERR consecutive errored beats, go to SEEK. Any clean beat resets the consecutive-error run.
- err_beat pulses in any state when a mismatch occurs. The counters update only in LOCKED.
- Counter arithmetic: sums are computed at ERR_CNT_W+1 bits and clamp at all-ones. Once saturated, a counter holds until clr_cnt.
- clr_cnt asserted in the same cycle as an error: clear wins and the counter reads 0. The error in that cycle is not counted.
- A change of poly_sel (detected against a registered copy) causes two things on the next edge: the generator reloads PRBS_INIT, and the checker goes to SEEK. The counters are kept.

## Timing
- Reset values: dout = 0, dout_vld = 0, locked = 0, err_beat = 0, both counters = 0, checker state = SEEK.
- Generator latency: gen_en at cycle t gives dout and dout_vld at t+1. dout_vld is low in cycles without gen_en, and dout holds its value.
- Checker latency: chk_vld at t gives err_beat, the counter updates and the locked change at t+1.
- Back-to-back chk_vld is supported every cycle. Gaps in chk_vld do not advance the predicted state.
- Minimum time to lock: 1 + LOCK_CNT valid beats, so locked rises at the clk edge after the (LOCK_CNT+1)th valid beat.
- An asynchronous rst mid-stream returns everything to the reset values immediately.

## Configuration
- PRBS_ERR_INJECT_EN defined: inject_err is registered through a 3-flop chain. A rising edge arms a flag. The next generated beat is emitted with dout[0] inverted, and the flag then clears. The generator state is not affected.
- PRBS_ERR_INJECT_EN undefined: the inject_err port remains but is ignored. No flops are generated and dout is the pure sequence.

## Structure
- prbs_pkg holds:
  - poly_sel encodings and the tap constants N and T for each polynomial;
  - the checker state enum: SEEK, VERIFY, LOCKED;
  - the popcount function.
- Sub-module prbs_step: combinational DATA_W-step advance with inputs poly_sel and state, and outputs next state and beat. It is instantiated twice, once for the generator and once for the checker.

## Test plan
- DATA_W=32, PRBS7, seed all-ones, one gen_en → dout[31:26]=6'b000000, dout[25]=1, dout_vld high for exactly 1 cycle.
- Loop dout to chk_din with PRBS31, 20 beats → locked rises after beat 9, err_beat never pulses, both counters 0.
- While locked, flip 3 bits of one beat → one err_beat pulse, err_beat_cnt=1, err_bit_cnt=3, locked stays 1.
- While locked, corrupt 4 consecutive beats → locked falls after the 4th; clean traffic then relocks after 9 beats.
- With PRBS_ERR_INJECT_EN defined, pulse inject_err during loopback → err_bit_cnt=1. With the macro undefined → err_bit_cnt=0.
- Preload err_beat_cnt to all-ones minus 1, apply 3 errored beats → the counter holds at all-ones. clr_cnt together with an error → 0.
